// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT definitions: polynomial, frame FSM states and the byte update function.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC_HI,
        CRC_LO,
        WAIT_LAST
    } state_t;

    // MSB-first, non-reflected: eight serial shift steps folded into one call.
    function automatic logic [15:0] crc16_byte_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[3'(7 - i)]) ? CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_byte_engine.sv
// Registered byte-wide CRC-16 with init and update enables; also used by the receive-side checker.
module crc16_byte_engine
    import crc16_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        upd_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d, seed;

    // init together with upd folds the first byte into a freshly seeded register.
    always_comb begin
        seed  = init_i ? CRC_INIT : crc_q;
        crc_d = upd_i ? crc16_byte_update(seed, data_i) : seed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc16_frame_sequencer.sv
// Forwards framed payload bytes and appends the CRC-16/CCITT (high byte first) after each frame.
module crc16_frame_sequencer
    import crc16_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [15:0]      crc_out,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             frame_done
);

    state_t           state_q;
    logic [7:0]       m_data_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic             frame_done_q;

    logic out_free;
    logic in_hs;
    logic done;
    logic crc_init;
    logic [15:0] crc_q;

    always_comb begin
        out_free = !m_valid_q || m_ready;
        s_ready  = ((state_q == IDLE) || (state_q == DATA)) && out_free;
        in_hs    = s_valid && s_ready;
        done     = (state_q == WAIT_LAST) && m_valid_q && m_ready;
        crc_init = ((state_q == IDLE) && in_hs) || done;
    end

    crc16_byte_engine #(
        .CRC_INIT (CRC_INIT)
    ) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_i (crc_init),
        .upd_i  (in_hs),
        .data_i (s_data),
        .crc_o  (crc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            byte_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // A completed handshake empties the output register unless a load below refills it.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        byte_cnt_q <= CNT_W'(1);
                        m_data_q   <= s_data;
                        m_valid_q  <= 1'b1;
                        m_last_q   <= 1'b0;
                        state_q    <= s_last ? CRC_HI : DATA;
                    end
                end
                DATA: begin
                    if (in_hs) begin
                        if (byte_cnt_q != '1) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                        m_data_q  <= s_data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        if (s_last) begin
                            state_q <= CRC_HI;
                        end
                    end
                end
                CRC_HI: begin
                    if (out_free) begin
                        m_data_q  <= crc_q[15:8];
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        state_q   <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (out_free) begin
                        m_data_q  <= crc_q[7:0];
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b1;
                        state_q   <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (done) begin
                        frame_done_q <= 1'b1;
                        byte_cnt_q   <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign crc_out    = crc_q;
    assign byte_cnt   = byte_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_crc16_frame_sequencer.sv
// Bench for crc16_frame_sequencer: frame table plus hand-written back-to-back and reset sequences.
module tb_crc16_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] crc_out;
    logic [15:0] byte_cnt;
    logic        frame_done;

    always #5 clk = ~clk;

    crc16_frame_sequencer #(
        .CRC_INIT (16'hFFFF),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .crc_out    (crc_out),
        .byte_cnt   (byte_cnt),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0]  d [9];
        int          n;
        bit          bp;
        bit          gaps;
        logic [15:0] crc;
    } vec_t;

    vec_t       vecs [5];
    logic [8:0] sb [$];
    int         n_pass   = 0;
    int         n_total  = 0;
    int         fd_count = 0;
    bit         bp_mode  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference CRC written directly from the bit-serial definition.
    function automatic logic [15:0] crc_model(input logic [7:0] d [9], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[k][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        bit         stalled;
        logic [8:0] prev;
        logic [8:0] exp;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_hold", {23'd0, m_last, m_data}, {23'd0, prev});
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        exp = sb.pop_front();
                        chk("out_byte", {23'd0, m_last, m_data}, {23'd0, exp});
                    end
                end
                stalled = m_valid && !m_ready;
                prev    = {m_last, m_data};
                if (frame_done) fd_count++;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d [9], input int n, input bit is_frame,
                              input bit gaps, input logic [15:0] exp_crc, output int first_wait);
        int waited;
        first_wait = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                end
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = is_frame && (i == n - 1);
            waited  = 0;
            while (1) begin
                #1;
                if (s_ready) break;
                waited++;
                if (waited > 500) begin
                    $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
                    $fatal(1);
                end
                @(negedge clk);
            end
            if (i == 0) first_wait = waited;
            @(posedge clk);
            sb.push_back({1'b0, d[i]});
        end
        #1;
        if (is_frame) begin
            sb.push_back({1'b0, exp_crc[15:8]});
            sb.push_back({1'b1, exp_crc[7:0]});
            chk("crc_out_final", {16'd0, crc_out}, {16'd0, exp_crc});
            chk("byte_cnt_final", {16'd0, byte_cnt}, 32'(n));
        end
    endtask

    task automatic wait_done(input int target);
        int c;
        c = 0;
        s_valid = 1'b0;
        while (fd_count < target) begin
            @(negedge clk);
            #3;
            c++;
            if (c > 300) begin
                chk("frame_done_timeout", 32'(fd_count), 32'(target));
                break;
            end
        end
        chk("frame_done_count", 32'(fd_count), 32'(target));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("byte_cnt_clear", {16'd0, byte_cnt}, 32'd0);
        @(negedge clk);
        #3;
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        chk("crc_reinit", {16'd0, crc_out}, 32'h0000FFFF);
    endtask

    initial begin
        logic [7:0] s123 [9];
        logic [7:0] s00  [9];
        logic [7:0] sx   [9];
        logic [7:0] d12  [9];
        logic [7:0] d34  [9];
        int         w;
        int         target;

        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        s00  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sx   = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        d12  = '{8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        d34  = '{8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        vecs[0].d = s123; vecs[0].n = 9; vecs[0].bp = 0; vecs[0].gaps = 0; vecs[0].crc = 16'h29B1;
        vecs[1].d = s00;  vecs[1].n = 1; vecs[1].bp = 0; vecs[1].gaps = 0; vecs[1].crc = 16'hE1F0;
        vecs[2].d = s123; vecs[2].n = 9; vecs[2].bp = 1; vecs[2].gaps = 0; vecs[2].crc = 16'h29B1;
        vecs[3].d = s123; vecs[3].n = 9; vecs[3].bp = 0; vecs[3].gaps = 1; vecs[3].crc = 16'h29B1;
        vecs[4].d = sx;   vecs[4].n = 5; vecs[4].bp = 1; vecs[4].gaps = 1; vecs[4].crc = crc_model(sx, 5);

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        chk("rst_crc", {16'd0, crc_out}, 32'h0000FFFF);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        target = 0;

        for (int k = 0; k < 5; k++) begin
            bp_mode = vecs[k].bp;
            send_frame(vecs[k].d, vecs[k].n, 1'b1, vecs[k].gaps, vecs[k].crc, w);
            target++;
            wait_done(target);
            bp_mode = 1'b0;
        end

        // Back-to-back frames with s_valid held: second byte stream waits out CRC_HI..WAIT_LAST.
        send_frame(d12, 2, 1'b1, 1'b0, crc_model(d12, 2), w);
        send_frame(d34, 2, 1'b1, 1'b0, crc_model(d34, 2), w);
        chk("b2b_bubble", 32'(w), 32'd3);
        target += 2;
        wait_done(target);

        // Reset after four payload bytes aborts the frame without emitting CRC bytes.
        send_frame(s123, 4, 1'b0, 1'b0, 16'h0000, w);
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        chk("abort_crc", {16'd0, crc_out}, 32'h0000FFFF);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(s123, 9, 1'b1, 1'b0, 16'h29B1, w);
        target++;
        wait_done(target);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/crc16_frame_sequencer.md
Name: crc16_frame_sequencer

Overview:
Sequences a byte-wide CRC-16/CCITT engine over framed byte streams. Accepts bytes on a valid/ready input stream and forwards them unchanged to an output stream. After the last payload byte, it appends the two CRC bytes, high byte first, and marks the final CRC byte as last. The block sits between the packet source and the serialiser and owns the CRC register, the init/clear sequencing and the frame state machine.

Parameters:
CRC_INIT, 16'hFFFF, CRC register value loaded at the start of every frame.
CNT_W, 16, width of the per-frame payload byte counter (saturating).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
s_data  input  8  payload byte.
s_valid  input  1  s_data valid.
s_last  input  1  s_data is the final payload byte of the frame.
s_ready  output  1  block accepts s_data this cycle.
m_data  output  8  output byte (payload or CRC).
m_valid  output  1  m_data valid.
m_last  output  1  m_data is the final byte of the frame (CRC low byte).
m_ready  input  1  downstream accepts m_data.
crc_out  output  16  running CRC; final frame CRC while in CRC_HI/CRC_LO.
byte_cnt  output  CNT_W  payload bytes accepted in the current frame.
frame_done  output  1  one-cycle pulse when the CRC low byte handshakes.

Behaviour:
- Reset: clk and rst_n are fixed as one clock with an asynchronous active-low reset. Reset values: state=IDLE, crc=CRC_INIT, m_valid=0, m_data=0, m_last=0, byte_cnt=0, frame_done=0.
- CRC math: polynomial 0x1021, MSB-first, no reflection, no final XOR. Per byte: 8 serial steps unrolled in one cycle, c = {c[14:0],0} ^ (c[15]^d[7-i] ? 16'h1021 : 0).
- Output register: single stage. Load is allowed when !m_valid || m_ready. The output holds m_data/m_last stable while m_valid && !m_ready.
- s_ready = (state==IDLE || state==DATA) && (!m_valid || m_ready). It is combinational from state and m_ready.
- IDLE: on input handshake, crc <= update(CRC_INIT, s_data), byte_cnt <= 1, m_data <= s_data, m_valid <= 1, m_last <= 0. Go to DATA, or to CRC_HI if s_last.
- DATA: each input handshake updates crc, increments byte_cnt (saturates at all-ones) and loads m_data. On s_last, go to CRC_HI.
- CRC_HI: when the output register is free, load m_data=crc[15:8], m_last=0, then go to CRC_LO.
- CRC_LO: when the output register is free, load m_data=crc[7:0], m_last=1, then go to WAIT_LAST.
- WAIT_LAST: when m_valid && m_ready, pulse frame_done, set crc <= CRC_INIT and byte_cnt <= 0, and return to IDLE.
- s_ready is low in CRC_HI, CRC_LO and WAIT_LAST. A back-to-back next frame therefore sees one bubble minimum after the CRC low byte is accepted.
- Latency: one cycle from input handshake to m_valid under m_ready=1. At m_ready=1 a frame of N bytes occupies N+2 output cycles.
- Bytes with s_valid=0 are never consumed. s_last is ignored unless s_valid && s_ready.
- m_valid de-asserts only after a handshake with no new load.
- Asynchronous reset mid-frame aborts the frame: no CRC bytes are emitted and all state returns to reset values.
- byte_cnt saturation does not affect CRC or framing.

Decomposition:
- Package crc16_pkg holds: CRC16_POLY=16'h1021, the state enum (IDLE, DATA, CRC_HI, CRC_LO, WAIT_LAST), and the function crc16_byte_update(crc, data).
- One sub-module, crc16_byte_engine. It is the registered CRC with init/update enable inputs and a 16-bit output, and it is reused by the receive-side checker.

Test Plan:
- Single frame "123456789" (0x31..0x39, last on 0x39), m_ready=1 -> output bytes 31..39, then 0x29, then 0xB1 with m_last=1; frame_done pulses once; byte_cnt=9 before clear.
- One-byte frame 0x00 -> m_data sequence 0x00, 0xE1, 0xF0 (m_last on 0xF0); crc_out=16'hE1F0 in CRC_HI.
- Random m_ready backpressure (about 50%) on the "123456789" frame -> m_data/m_last stable while stalled; identical byte sequence; no byte lost or duplicated.
- Two back-to-back frames "12" then "34" with s_valid held high -> second CRC computed from CRC_INIT (equals the single-frame result); s_ready low during CRC_HI through WAIT_LAST.
- rst_n asserted after 4 bytes of a frame -> immediate m_valid=0, byte_cnt=0, crc_out=16'hFFFF; next frame "123456789" yields 0x29B1.
- s_valid gaps inside a frame -> CRC unchanged versus the gap-free case.
